// File: rtl/ble_packet_encoder_if.sv
// Payload-in and byte-out streaming handshakes of the BLE packet encoder.
//   pl_byte/pl_valid/pl_ready : raw payload bytes into the encoder
//   tx_byte/tx_valid/tx_ready : framed (optionally whitened) bytes out to the serializer
// master: the host side (supplies payload, accepts tx bytes)
// slave : the encoder side
interface ble_packet_encoder_if;
    logic [7:0] pl_byte;
    logic       pl_valid;
    logic       pl_ready;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output pl_byte, pl_valid, tx_ready,
        input  pl_ready, tx_byte, tx_valid
    );

    modport slave (
        input  pl_byte, pl_valid, tx_ready,
        output pl_ready, tx_byte, tx_valid
    );
endinterface

// File: rtl/ble_packet_encoder.sv
// BLE link-layer packet encoder (transmit side).
// Emits preamble, access address, header, payload and CRC-24 as a byte stream.
// CRC covers the raw header and payload; optional whitening covers header, payload and CRC.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start           : request a packet (accepted only when idle)
//   hdr_in          : header byte, [5:0] = payload length (clamped to MAX_LEN)
//   whiten_en       : whitening enable, sampled with start
//   bus (slave)     : payload input stream and tx byte output stream
//   busy            : packet in progress
//   done            : one-cycle pulse after the last CRC byte is accepted
//   tx_state        : current state code
module ble_packet_encoder #(
    parameter logic [31:0] ACCESS_ADDR = 32'h8E89BED6,
    parameter logic [23:0] CRC_INIT    = 24'h555555,
    parameter int unsigned MAX_LEN     = 37
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [7:0]                 hdr_in,
    input  logic                       whiten_en,
    ble_packet_encoder_if.slave        bus,
    output logic                       busy,
    output logic                       done,
    output logic [7:0]                 tx_state
);

    typedef enum logic [7:0] {
        StIdle     = 8'd0,
        StPreamble = 8'd1,
        StAccess   = 8'd2,
        StHeader   = 8'd3,
        StPayload  = 8'd4,
        StCrc      = 8'd5
    } state_e;

    localparam logic [5:0] MaxLen   = 6'(MAX_LEN);
    // Preamble alternates starting with the same bit value as the first access-address bit.
    localparam logic [7:0] Preamble = ACCESS_ADDR[0] ? 8'h55 : 8'hAA;

    state_e      state_q;
    logic [7:0]  hdr_q;
    logic        wen_q;
    logic [5:0]  len_q;
    logic [5:0]  idx_q;
    logic [23:0] crc_q;
    logic [6:0]  lfsr_q;
    logic [7:0]  tx_byte_q;
    logic        tx_valid_q;

    logic        wbit;
    logic [7:0]  mask;
    logic [6:0]  lfsr_nxt;
    logic        accept;
    logic        pl_take;
    logic [5:0]  len_in;

    function automatic logic [23:0] crc_byte(input logic [23:0] c, input logic [7:0] b);
        logic [23:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[23] ^ b[i];
            r  = {r[22:0], 1'b0} ^ (fb ? 24'h00065B : 24'h000000);
        end
        return r;
    endfunction

    function automatic logic [7:0] access_byte(input logic [1:0] i);
        logic [7:0] b;
        case (i)
            2'd0:    b = ACCESS_ADDR[7:0];
            2'd1:    b = ACCESS_ADDR[15:8];
            2'd2:    b = ACCESS_ADDR[23:16];
            default: b = ACCESS_ADDR[31:24];
        endcase
        return b;
    endfunction

    always_comb begin
        wbit     = lfsr_q[6] ^ lfsr_q[3];
        mask     = wen_q ? {8{wbit}} : 8'h00;
        lfsr_nxt = {lfsr_q[5:0], wbit};
        accept   = tx_valid_q & bus.tx_ready;
        pl_take  = bus.pl_valid & bus.pl_ready;
        len_in   = (hdr_in[5:0] > MaxLen) ? MaxLen : hdr_in[5:0];
    end

    // Payload is pulled only while bytes remain and the output register frees up this cycle.
    assign bus.pl_ready = (state_q == StPayload) && (idx_q != len_q) &&
                          (!tx_valid_q || bus.tx_ready);
    assign bus.tx_byte  = tx_byte_q;
    assign bus.tx_valid = tx_valid_q;
    assign tx_state     = state_q;

    // LFSR/CRC advance when a byte is loaded into the output register; the count per
    // accepted byte is the same and stalls never reload, so nothing advances twice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            hdr_q      <= 8'h00;
            wen_q      <= 1'b0;
            len_q      <= 6'd0;
            idx_q      <= 6'd0;
            crc_q      <= CRC_INIT;
            lfsr_q     <= 7'h40;
            tx_byte_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (start) begin
                        hdr_q      <= hdr_in;
                        wen_q      <= whiten_en;
                        len_q      <= len_in;
                        crc_q      <= CRC_INIT;
                        lfsr_q     <= 7'h40;
                        idx_q      <= 6'd0;
                        tx_byte_q  <= Preamble;
                        tx_valid_q <= 1'b1;
                        busy       <= 1'b1;
                        state_q    <= StPreamble;
                    end
                end
                StPreamble: begin
                    if (accept) begin
                        tx_byte_q <= access_byte(2'd0);
                        idx_q     <= 6'd0;
                        state_q   <= StAccess;
                    end
                end
                StAccess: begin
                    if (accept) begin
                        if (idx_q[1:0] == 2'd3) begin
                            tx_byte_q <= hdr_q ^ mask;
                            crc_q     <= crc_byte(crc_q, hdr_q);
                            lfsr_q    <= lfsr_nxt;
                            state_q   <= StHeader;
                        end else begin
                            idx_q     <= idx_q + 6'd1;
                            tx_byte_q <= access_byte(idx_q[1:0] + 2'd1);
                        end
                    end
                end
                StHeader: begin
                    if (accept) begin
                        idx_q <= 6'd0;
                        if (len_q == 6'd0) begin
                            tx_byte_q <= crc_q[23:16] ^ mask;
                            lfsr_q    <= lfsr_nxt;
                            state_q   <= StCrc;
                        end else begin
                            tx_valid_q <= 1'b0;
                            state_q    <= StPayload;
                        end
                    end
                end
                StPayload: begin
                    if (pl_take) begin
                        tx_byte_q  <= bus.pl_byte ^ mask;
                        tx_valid_q <= 1'b1;
                        crc_q      <= crc_byte(crc_q, bus.pl_byte);
                        lfsr_q     <= lfsr_nxt;
                        idx_q      <= idx_q + 6'd1;
                    end else if (accept) begin
                        if (idx_q == len_q) begin
                            tx_byte_q <= crc_q[23:16] ^ mask;
                            lfsr_q    <= lfsr_nxt;
                            idx_q     <= 6'd0;
                            state_q   <= StCrc;
                        end else begin
                            tx_valid_q <= 1'b0;
                        end
                    end
                end
                StCrc: begin
                    if (accept) begin
                        case (idx_q[1:0])
                            2'd0: begin
                                tx_byte_q <= crc_q[15:8] ^ mask;
                                lfsr_q    <= lfsr_nxt;
                                idx_q     <= 6'd1;
                            end
                            2'd1: begin
                                tx_byte_q <= crc_q[7:0] ^ mask;
                                lfsr_q    <= lfsr_nxt;
                                idx_q     <= 6'd2;
                            end
                            default: begin
                                tx_valid_q <= 1'b0;
                                busy       <= 1'b0;
                                done       <= 1'b1;
                                state_q    <= StIdle;
                            end
                        endcase
                    end
                end
                default: begin
                    tx_valid_q <= 1'b0;
                    busy       <= 1'b0;
                    state_q    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ble_packet_encoder.sv
module tb_ble_packet_encoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] hdr_in = 8'h00;
    logic       whiten_en = 1'b0;
    logic       busy;
    logic       done;
    logic [7:0] tx_state;

    ble_packet_encoder_if bus ();

    ble_packet_encoder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .hdr_in    (hdr_in),
        .whiten_en (whiten_en),
        .bus       (bus),
        .busy      (busy),
        .done      (done),
        .tx_state  (tx_state)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    // Reference model: bit-serial CRC-24, LSB of each byte first.
    function automatic logic [23:0] m_crc(input logic [23:0] c, input logic [7:0] b);
        logic [23:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[23] ^ b[i]) r = {r[22:0], 1'b0} ^ 24'h00065B;
            else              r = {r[22:0], 1'b0};
        end
        return r;
    endfunction

    function automatic logic [7:0] pl_val(input logic [7:0] base, input int i);
        return base + 8'(i * 17);
    endfunction

    function automatic int clamp_len(input logic [7:0] hdr);
        return (int'(hdr[5:0]) > 37) ? 37 : int'(hdr[5:0]);
    endfunction

    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         done_cnt;
    int         stable_err;
    int         starve_err;
    bit         timed_out;

    task automatic build_expected(input logic [7:0] hdr, input logic wen, input logic [7:0] base);
        logic [7:0]  raw[$];
        logic [23:0] crc;
        logic [6:0]  lfsr;
        logic        w;
        exp_q.delete();
        exp_q.push_back(8'hAA);
        exp_q.push_back(8'hD6);
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'h89);
        exp_q.push_back(8'h8E);
        crc = 24'h555555;
        raw.push_back(hdr);
        crc = m_crc(crc, hdr);
        for (int i = 0; i < clamp_len(hdr); i++) begin
            raw.push_back(pl_val(base, i));
            crc = m_crc(crc, pl_val(base, i));
        end
        raw.push_back(crc[23:16]);
        raw.push_back(crc[15:8]);
        raw.push_back(crc[7:0]);
        lfsr = 7'h40;
        foreach (raw[i]) begin
            w = lfsr[6] ^ lfsr[3];
            exp_q.push_back(raw[i] ^ (wen ? {8{w}} : 8'h00));
            lfsr = {lfsr[5:0], w};
        end
    endtask

    // Drives one packet and collects accepted tx bytes; returns in the done cycle.
    task automatic run_packet(input logic [7:0] hdr, input logic wen, input logic [7:0] base,
                              input int stall_at, input int stall_len,
                              input int starve_at, input int starve_len,
                              input bit poke, input bit started);
        int         pl_idx = 0;
        int         stall_left = stall_len;
        int         starve_left = starve_len;
        int         starve_n = 0;
        int         len;
        bit         prev_stall = 1'b0;
        logic [7:0] prev_byte = 8'h00;
        bit         fin = 1'b0;
        len = clamp_len(hdr);
        got_q.delete();
        done_cnt   = 0;
        stable_err = 0;
        starve_err = 0;
        if (!started) begin
            start = 1'b1;
            hdr_in = hdr;
            whiten_en = wen;
            @(posedge clk); #1;
            start = 1'b0;
            check("start_latency", {22'd0, busy, bus.tx_valid, tx_state}, {22'd0, 2'b11, 8'd1});
        end
        hdr_in = 8'h00;
        whiten_en = 1'b0;
        for (int cyc = 0; cyc < 400 && !fin; cyc++) begin
            if (poke && cyc == 3) begin
                start = 1'b1;
                hdr_in = 8'h05;
                whiten_en = ~wen;
            end else begin
                start = 1'b0;
            end
            if (prev_stall && (!bus.tx_valid || bus.tx_byte !== prev_byte)) stable_err++;
            if (bus.tx_valid && got_q.size() == stall_at && stall_left > 0) begin
                bus.tx_ready = 1'b0;
                stall_left--;
            end else begin
                bus.tx_ready = 1'b1;
            end
            #1;
            if (pl_idx < len) begin
                bus.pl_byte = pl_val(base, pl_idx);
                if (pl_idx == starve_at && starve_left > 0 && bus.pl_ready) begin
                    bus.pl_valid = 1'b0;
                    if (starve_n > 0 && bus.tx_valid) starve_err++;
                    starve_n++;
                    starve_left--;
                end else begin
                    bus.pl_valid = 1'b1;
                end
            end else begin
                bus.pl_valid = 1'b0;
            end
            #1;
            prev_stall = bus.tx_valid && !bus.tx_ready;
            prev_byte  = bus.tx_byte;
            if (bus.tx_valid && bus.tx_ready) got_q.push_back(bus.tx_byte);
            if (bus.pl_valid && bus.pl_ready) pl_idx++;
            if (done) begin
                done_cnt++;
                fin = 1'b1;
            end
            if (!fin) begin
                @(posedge clk); #1;
            end
        end
        start = 1'b0;
        bus.pl_valid = 1'b0;
        bus.tx_ready = 1'b1;
        timed_out = !fin;
    endtask

    task automatic compare_stream(input string tag);
        check({tag, "_timeout"}, 32'(timed_out), 32'd0);
        check({tag, "_nbytes"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) check($sformatf("%s_byte%0d", tag, i), got_q[i], exp_q[i]);
        end
    endtask

    typedef struct {
        logic [7:0] hdr;
        logic       wen;
        logic [7:0] base;
        int         stall_at;
        int         stall_len;
        int         starve_at;
        int         starve_len;
        bit         poke;
        logic [7:0] exp_hdr_out;
        int         exp_n;
    } vec_t;

    vec_t vecs[8];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int extra_done;
        // hdr, wen, base, stall_at, stall_len, starve_at, starve_len, poke, exp_hdr_out, exp_n
        vecs[0] = '{8'h03, 1'b0, 8'h11, -1,  0, -1, 0, 1'b0, 8'h03, 12};  // plain framing
        vecs[1] = '{8'h03, 1'b1, 8'h11, -1,  0, -1, 0, 1'b0, 8'hFC, 12};  // whitened
        vecs[2] = '{8'h03, 1'b0, 8'h11,  5,  5, -1, 0, 1'b0, 8'h03, 12};  // header backpressure
        vecs[3] = '{8'h03, 1'b1, 8'h11, -1,  0,  1, 4, 1'b0, 8'hFC, 12};  // payload starvation
        vecs[4] = '{8'h00, 1'b0, 8'h11, -1,  0, -1, 0, 1'b0, 8'h00,  9};  // zero length
        vecs[5] = '{8'h3F, 1'b1, 8'h07, -1,  0, -1, 0, 1'b0, 8'hC0, 46};  // clamp to 37
        vecs[6] = '{8'h03, 1'b0, 8'h11, -1,  0, -1, 0, 1'b1, 8'h03, 12};  // start while busy
        vecs[7] = '{8'hC5, 1'b1, 8'hA0, 11,  3, -1, 0, 1'b0, 8'h3A, 14};  // stall on CRC byte

        bus.pl_byte  = 8'h00;
        bus.pl_valid = 1'b0;
        bus.tx_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_flags", {28'd0, bus.tx_valid, busy, done, bus.pl_ready}, 32'd0);
        check("reset_state", tx_state, 8'd0);
        check("reset_tx_byte", bus.tx_byte, 8'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int v = 0; v < 8; v++) begin
            build_expected(vecs[v].hdr, vecs[v].wen, vecs[v].base);
            check($sformatf("v%0d_model_len", v), exp_q.size(), vecs[v].exp_n);
            run_packet(vecs[v].hdr, vecs[v].wen, vecs[v].base, vecs[v].stall_at,
                       vecs[v].stall_len, vecs[v].starve_at, vecs[v].starve_len,
                       vecs[v].poke, 1'b0);
            compare_stream($sformatf("v%0d", v));
            if (got_q.size() > 5) check($sformatf("v%0d_hdr_out", v), got_q[5], vecs[v].exp_hdr_out);
            check($sformatf("v%0d_done_cnt", v), done_cnt, 1);
            check($sformatf("v%0d_stable", v), stable_err, 0);
            check($sformatf("v%0d_starve", v), starve_err, 0);
            check($sformatf("v%0d_end_idle", v), {22'd0, busy, bus.tx_valid, tx_state}, 32'd0);
            extra_done = 0;
            repeat (3) begin
                @(posedge clk); #1;
                if (done) extra_done++;
            end
            check($sformatf("v%0d_single_done", v), extra_done, 0);
        end

        // Start in the done cycle begins the next packet with no idle gap.
        build_expected(8'h03, 1'b1, 8'h11);
        run_packet(8'h03, 1'b1, 8'h11, -1, 0, -1, 0, 1'b0, 1'b0);
        compare_stream("chain_a");
        check("chain_done_seen", done, 1'b1);
        start = 1'b1;
        hdr_in = 8'h00;
        whiten_en = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        check("chain_no_gap", {14'd0, busy, bus.tx_valid, tx_state, bus.tx_byte},
              {14'd0, 2'b11, 8'd1, 8'hAA});
        build_expected(8'h00, 1'b0, 8'h11);
        run_packet(8'h00, 1'b0, 8'h11, -1, 0, -1, 0, 1'b0, 1'b1);
        compare_stream("chain_b");
        @(posedge clk); #1;

        // Asynchronous reset while waiting for payload, then a fresh packet.
        begin
            bit reached = 1'b0;
            start = 1'b1;
            hdr_in = 8'h03;
            whiten_en = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            bus.tx_ready = 1'b1;
            bus.pl_valid = 1'b0;
            for (int c = 0; c < 30 && !reached; c++) begin
                if (tx_state == 8'd4) reached = 1'b1;
                else begin
                    @(posedge clk); #1;
                end
            end
            check("rst_mid_reached_payload", 32'(reached), 32'd1);
            rst_n = 1'b0;
            #1;
            check("rst_mid_flags", {29'd0, bus.tx_valid, busy, done}, 32'd0);
            check("rst_mid_state", tx_state, 8'd0);
            @(posedge clk); #1;
            check("rst_mid_held", {22'd0, bus.tx_valid, busy, tx_state}, 32'd0);
            rst_n = 1'b1;
            @(posedge clk); #1;
            build_expected(8'h03, 1'b0, 8'h11);
            run_packet(8'h03, 1'b0, 8'h11, -1, 0, -1, 0, 1'b0, 1'b0);
            compare_stream("after_reset");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
